// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: default widths, sequencer state encoding and the
// zero-extended constant 1 used for the final conversion out of the Montgomery domain.
package rsa_pkg;

  localparam int unsigned NDefault      = 512;
  localparam int unsigned EWidthDefault = 512;

  // Montgomery-domain exit multiplies by plain 1; slice to the instance width with ONE_N[N-1:0].
  localparam logic [NDefault-1:0] ONE_N = NDefault'(1);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StSkip    = 4'd1,
    StSqReq   = 4'd2,
    StSqWait  = 4'd3,
    StMulReq  = 4'd4,
    StMulWait = 4'd5,
    StFinReq  = 4'd6,
    StFinWait = 4'd7,
    StDone    = 4'd8
  } state_e;

endpackage

// File: rtl/mont_req_reg.sv
// Request register toward the Montgomery multiplier: registered start pulse and operands,
// one outstanding multiplication at a time, operands frozen until the matching done.
module mont_req_reg #(
  parameter int unsigned N = 512
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req_i,
  input  logic         load_m_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] m_i,
  input  logic         done_i,
  output logic         start_o,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o,
  output logic [N-1:0] m_o
);

  logic         start_q, start_d;
  logic         pend_q, pend_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic         accept;

  // A completion in the same cycle frees the slot for the next request.
  assign accept = req_i && (!pend_q || done_i);

  // Next-state: load operands only on an accepted request; the modulus only on a new job.
  always_comb begin
    start_d = accept;
    a_d     = accept ? a_i : a_q;
    b_d     = accept ? b_i : b_q;
    m_d     = load_m_i ? m_i : m_q;
    pend_d  = pend_q;
    if (accept) begin
      pend_d = 1'b1;
    end else if (done_i) begin
      pend_d = 1'b0;
    end
  end

  // Request state register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start_q <= 1'b0;
      pend_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
    end else begin
      start_q <= start_d;
      pend_q  <= pend_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
    end
  end

  assign start_o = start_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign m_o     = m_q;

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for one Montgomery multiplier.
// Optional build macro MODEXP_LEADING_ZERO_SKIP_EN skips squarings of leading zero exponent bits.
module mont_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned N       = NDefault,
  parameter int unsigned E_WIDTH = EWidthDefault,
  parameter int unsigned ELEN_W  = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N-1:0]       in_x_mont,
  input  logic [N-1:0]       in_r_mod_m,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [ELEN_W-1:0]  in_e_len,
  input  logic [N-1:0]       in_m,
  output logic [N-1:0]       result,
  output logic               done,
  output logic               busy,
  output logic               mm_start,
  output logic [N-1:0]       mm_in_a,
  output logic [N-1:0]       mm_in_b,
  output logic [N-1:0]       mm_in_m,
  input  logic [N-1:0]       mm_result,
  input  logic               mm_done
);

  localparam logic [ELEN_W-1:0] ELenMax = ELEN_W'(E_WIDTH);
  localparam logic [ELEN_W-1:0] IdxOne  = ELEN_W'(1);

  state_e              state_q, state_d;
  logic [N-1:0]        a_q, a_d, x_q, x_d, result_q, result_d;
  logic [E_WIDTH-1:0]  e_q, e_d;
  logic [ELEN_W-1:0]   idx_q, idx_d, len_clamped;
  logic                req, load_m, e_bit;
  logic [N-1:0]        req_a, req_b;

  assign len_clamped = (in_e_len > ELenMax) ? ELenMax : in_e_len;
  assign e_bit       = |(e_q & (E_WIDTH'(1) << idx_q));

`ifdef MODEXP_LEADING_ZERO_SKIP_EN
  logic e_bit_below;
  assign e_bit_below = |(e_q & (E_WIDTH'(1) << (idx_q - IdxOne)));
`endif

  // Next-state and datapath updates; requests launch on entry to a *_REQ state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    x_d      = x_q;
    e_d      = e_q;
    idx_d    = idx_q;
    result_d = result_q;
    load_m   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d    = in_x_mont;
          e_d    = in_e;
          a_d    = in_r_mod_m;
          idx_d  = len_clamped;
          load_m = 1'b1;
          if (len_clamped == '0) begin
            state_d = StFinReq;
          end else begin
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
            state_d = StSkip;
`else
            state_d = StSqReq;
`endif
          end
        end
      end
      StSkip: begin
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
        if (idx_q == '0) begin
          state_d = StFinReq;
        end else if (e_bit_below) begin
          state_d = StSqReq;
        end else begin
          idx_d = idx_q - IdxOne;
        end
`else
        state_d = StIdle;
`endif
      end
      StSqReq: begin
        idx_d   = idx_q - IdxOne;
        state_d = StSqWait;
      end
      StSqWait: begin
        if (mm_done) begin
          a_d = mm_result;
          if (e_bit)              state_d = StMulReq;
          else if (idx_q == '0)   state_d = StFinReq;
          else                    state_d = StSqReq;
        end
      end
      StMulReq: state_d = StMulWait;
      StMulWait: begin
        if (mm_done) begin
          a_d     = mm_result;
          state_d = (idx_q == '0) ? StFinReq : StSqReq;
        end
      end
      StFinReq: state_d = StFinWait;
      StFinWait: begin
        if (mm_done) begin
          result_d = mm_result;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Operands come from next-state values so mm_start lines up with the REQ state itself.
    req   = state_d inside {StSqReq, StMulReq, StFinReq};
    req_a = a_d;
    if (state_d == StMulReq)      req_b = x_d;
    else if (state_d == StFinReq) req_b = ONE_N[N-1:0];
    else                          req_b = a_d;
  end

  // Sequencer state register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      a_q      <= '0;
      x_q      <= '0;
      e_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      x_q      <= x_d;
      e_q      <= e_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  mont_req_reg #(
    .N(N)
  ) u_req (
    .clk     (clk),
    .resetn  (resetn),
    .req_i   (req),
    .load_m_i(load_m),
    .a_i     (req_a),
    .b_i     (req_b),
    .m_i     (in_m),
    .done_i  (mm_done),
    .start_o (mm_start),
    .a_o     (mm_in_a),
    .b_o     (mm_in_b),
    .m_o     (mm_in_m)
  );

  assign result = result_q;
  assign done   = (state_q == StDone);
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl at N=8 (R=256) with a behavioural Montgomery multiplier.
module tb_mont_modexp_ctrl;

  logic       clk = 1'b0;
  logic       resetn, start;
  logic [7:0] in_x_mont, in_r_mod_m, in_e, in_m;
  logic [3:0] in_e_len;
  logic [7:0] result, mm_in_a, mm_in_b, mm_in_m, mm_result;
  logic       done, busy, mm_start, mm_done;
  logic       mdl_done, spur;

  int n_cmp = 0;
  int n_fail = 0;
  int lat_force = 0;

  assign mm_done = mdl_done | spur;

  always #5 clk = ~clk;

  mont_modexp_ctrl #(
    .N(8), .E_WIDTH(8), .ELEN_W(4)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x_mont(in_x_mont), .in_r_mod_m(in_r_mod_m), .in_e(in_e),
    .in_e_len(in_e_len), .in_m(in_m),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_in_a(mm_in_a), .mm_in_b(mm_in_b), .mm_in_m(mm_in_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // a*b*R^-1 mod m with R = 256.
  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] m);
    int unsigned rinv, ai, bi, mi;
    rinv = 0; ai = a; bi = b; mi = m;
    for (int unsigned i = 1; i < mi; i++) if (((256 * i) % mi) == 1) rinv = i;
    if (mi == 0) return 8'd0;
    return 8'(((ai * bi) % mi * rinv) % mi);
  endfunction

  // Behavioural multiplier plus handshake/stability checker, all at the falling edge.
  int         mdl_cnt = 0;
  logic [7:0] mdl_res, cap_a, cap_b, cap_m;
  bit         track = 0, stab_bad = 0;
  initial begin
    mdl_done = 1'b0;
    mm_result = '0;
    forever begin
      @(negedge clk);
      mdl_done = 1'b0;
      if (!resetn) track = 0;
      if (track && mdl_cnt > 0 && !mm_start &&
          (mm_in_a !== cap_a || mm_in_b !== cap_b || mm_in_m !== cap_m)) stab_bad = 1;
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          mdl_done = 1'b1;
          mm_result = mdl_res;
          if (track) check("operand_stability", 64'(stab_bad), 64'd0);
          track = 0;
        end
      end
      if (resetn && mm_start) begin
        check("single_outstanding", 64'(mdl_cnt > 0), 64'd0);
        cap_a = mm_in_a; cap_b = mm_in_b; cap_m = mm_in_m;
        mdl_res = mont(mm_in_a, mm_in_b, mm_in_m);
        mdl_cnt = (lat_force > 0) ? lat_force : int'($urandom_range(20, 1));
        track = 1; stab_bad = 0;
      end
    end
  end

  typedef struct {
    logic [7:0] x, r, e, m;
    logic [3:0] len;
    logic [7:0] res;
    int         st_noskip, st_skip;
  } vec_t;

  vec_t vecs[9];

  task automatic run_op(input vec_t v, input bit poke, output logic [7:0] res, output int st,
                        output int dn, output bit busy_ok, output bit tmo);
    bit poked = 0, unpoke = 0;
    res = '0; st = 0; dn = 0; busy_ok = 1; tmo = 1;
    @(negedge clk);
    in_x_mont = v.x; in_r_mod_m = v.r; in_e = v.e; in_m = v.m; in_e_len = v.len;
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (unpoke) begin
        in_x_mont = v.x; in_r_mod_m = v.r; in_e = v.e; in_m = v.m; in_e_len = v.len;
        unpoke = 0;
      end
      if (mm_start) st++;
      if (!busy) busy_ok = 0;
      if (poke && !poked && st == 1 && !mm_start && busy) begin
        start = 1'b1; in_x_mont = 8'd3; in_r_mod_m = 8'd1; in_e = 8'd7; in_m = 8'd7;
        in_e_len = 4'd3; poked = 1; unpoke = 1;
      end
      if (done) begin
        res = result; dn++; tmo = 0;
        break;
      end
    end
    repeat (2) begin
      @(negedge clk);
      if (done) dn++;
    end
  endtask

  logic [7:0] r;
  int         st, dn, k;
  bit         bok, tmo;
  int         exp_st;

  initial begin
    resetn = 1'b0; start = 1'b0; spur = 1'b0;
    in_x_mont = '0; in_r_mod_m = '0; in_e = '0; in_m = '0; in_e_len = '0;
    vecs[0] = '{8'd6, 8'd9, 8'h03, 8'd13, 4'd2,  8'd8, 5,  5};
    vecs[1] = '{8'd6, 8'd9, 8'h04, 8'd13, 4'd4,  8'd1, 6,  5};
    vecs[2] = '{8'd6, 8'd9, 8'hAB, 8'd13, 4'd0,  8'd1, 1,  1};
    vecs[3] = '{8'd6, 8'd9, 8'h00, 8'd13, 4'd3,  8'd1, 4,  1};
    vecs[4] = '{8'd6, 8'd9, 8'hF3, 8'd13, 4'd2,  8'd8, 5,  5};
    vecs[5] = '{8'd6, 8'd9, 8'h03, 8'd13, 4'd15, 8'd8, 11, 5};
    vecs[6] = '{8'd5, 8'd9, 8'h05, 8'd13, 4'd3,  8'd6, 6,  6};
    vecs[7] = '{8'd6, 8'd9, 8'h01, 8'd13, 4'd1,  8'd5, 3,  3};
    vecs[8] = '{8'd9, 8'd3, 8'h02, 8'd11, 4'd2,  8'd9, 4,  4};

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({result, done, busy, mm_start, mm_in_a, mm_in_b, mm_in_m}), 64'd0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
      exp_st = vecs[i].st_skip;
`else
      exp_st = vecs[i].st_noskip;
`endif
      run_op(vecs[i], 1'b0, r, st, dn, bok, tmo);
      check($sformatf("v%0d_timeout", i), 64'(tmo), 64'd0);
      check($sformatf("v%0d_result", i), 64'(r), 64'(vecs[i].res));
      check($sformatf("v%0d_mm_starts", i), 64'(st), 64'(exp_st));
      check($sformatf("v%0d_done_pulses", i), 64'(dn), 64'd1);
      check($sformatf("v%0d_busy", i), 64'(bok), 64'd1);
    end

    // Start while busy must not disturb the running job.
    run_op(vecs[0], 1'b1, r, st, dn, bok, tmo);
    check("busy_start_result", 64'(r), 64'd8);
    check("busy_start_starts", 64'(st), 64'd5);
    check("busy_start_done", 64'(dn), 64'd1);

    // Spurious mm_done in IDLE.
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    check("spurious_state", 64'({busy, done, mm_start}), 64'd0);
    check("spurious_result", 64'(result), 64'd8);
    @(negedge clk);
    check("spurious_after", 64'({busy, done, mm_start}), 64'd0);

    // Reset in MUL_WAIT, late done ignored, then a clean rerun.
    lat_force = 12;
    @(negedge clk);
    in_x_mont = 8'd6; in_r_mod_m = 8'd9; in_e = 8'h03; in_m = 8'd13; in_e_len = 4'd2;
    start = 1'b1;
    k = 0;
    for (int c = 0; c < 200 && k < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mm_start) k++;
    end
    check("abort_reach_mul", 64'(k), 64'd2);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_outputs", 64'({result, done, busy, mm_start, mm_in_a, mm_in_b, mm_in_m}), 64'd0);
    resetn = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k == 0; c++) begin
      @(negedge clk);
      if (mdl_done) k = 1;
      if (busy || done || mm_start) k = 2;
    end
    check("abort_late_done_seen", 64'(k), 64'd1);
    @(negedge clk);
    check("abort_idle_after", 64'({busy, done, mm_start}), 64'd0);
    lat_force = 0;
    run_op(vecs[0], 1'b0, r, st, dn, bok, tmo);
    check("abort_rerun_result", 64'(r), 64'd8);
    check("abort_rerun_starts", 64'(st), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
